// File: rtl/mips32_prog_loader_if.sv
// Host byte stream and Mem write port of the program loader.
// The loader sits on the slave side: it consumes the stream and drives the Mem write port.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader for the MIPS32 core: packs host bytes into words, writes Mem,
// launches the core at the load base and watches for HLT with a watchdog.
//
// state   | meaning
// IDLE    | waiting for load_start, core held
// LOAD    | accepting bytes, writing one word per 4 bytes
// RELEASE | one-cycle core_start pulse with core_pc = base
// RUN     | core running, watchdog counting
// DONE    | core halted normally
// ERR     | bad range or watchdog expiry, core held
module mips32_prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                load_start,
  input  logic [ADDR_W-1:0]   load_base,
  input  logic [ADDR_W:0]     load_count,
  mips32_prog_loader_if.slave bus,
  output logic                core_hold,
  output logic                core_start,
  output logic [31:0]         core_pc,
  input  logic                core_halted,
  output logic                busy,
  output logic                done,
  output logic [1:0]          error,
  output logic [31:0]         checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W+1:0] DEPTH_LIM = (ADDR_W+2)'(DEPTH);
  localparam logic [31:0]       TO_LIM    = 32'(TIMEOUT_CYC) - 32'd1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   words_q;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       wd;

  logic              start_acc;
  logic              range_bad;
  logic              byte_acc;
  logic              s_ready_c;
  logic              wd_timeout;
  logic [ADDR_W+1:0] end_addr;
  logic [ADDR_W-1:0] wr_addr;

  // one bit of headroom beyond base+count so the range check never wraps
  assign end_addr   = {2'b00, load_base} + {1'b0, load_count};
  assign range_bad  = (load_count == '0) || (end_addr > DEPTH_LIM);
  assign start_acc  = load_start &&
                      (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign wr_addr    = base_q + words_q[ADDR_W-1:0];
  assign s_ready_c  = !rst && (state == S_LOAD) && (words_q != cnt_q);
  assign byte_acc   = bus.s_valid && s_ready_c;
  assign wd_timeout = (TIMEOUT_CYC != 0) && (state == S_RUN) && !core_halted &&
                      (wd >= TO_LIM);

  always_ff @(posedge clk1) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start_acc) state_d = range_bad ? S_ERR : S_LOAD;
      S_LOAD:
        if (mem_we_q && (words_q == cnt_q)) state_d = S_RELEASE;
      S_RELEASE:
        state_d = S_RUN;
      S_RUN:
        if (core_halted)     state_d = S_DONE;
        else if (wd_timeout) state_d = S_ERR;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      base_q      <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      checksum    <= '0;
      error       <= 2'b00;
      wd          <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (mem_we_q) checksum <= checksum + mem_wdata_q;
      if (start_acc) begin
        if (range_bad) begin
          error <= 2'b01;
        end else begin
          base_q   <= load_base;
          cnt_q    <= load_count;
          words_q  <= '0;
          byte_cnt <= '0;
          checksum <= '0;
          error    <= 2'b00;
        end
      end
      if (byte_acc) begin
        if (byte_cnt == 2'd3) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= wr_addr;
          mem_wdata_q <= {shreg, bus.s_data};
          words_q     <= words_q + 1'b1;
          byte_cnt    <= 2'd0;
        end else begin
          shreg    <= {shreg[15:0], bus.s_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
      // wd holds the number of cycles elapsed since the RELEASE cycle
      if (state == S_RELEASE)  wd <= 32'd1;
      else if (state == S_RUN) wd <= wd + 32'd1;
      if (wd_timeout) error <= 2'b10;
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign core_start = !rst && (state == S_RELEASE);
  assign core_pc    = core_start ? 32'(base_q) : 32'd0;
  assign core_hold  = rst || !(state == S_RELEASE || state == S_RUN || state == S_DONE);
  assign busy       = (state == S_LOAD) || (state == S_RELEASE) || (state == S_RUN);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: scoreboard on the Mem write port plus a tiny
// core model that executes ADDI/ADD/HLT from the bench-side Mem copy.
module tb_mips32_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        load_start;
  logic [9:0]  load_base;
  logic [10:0] load_count;
  logic        core_hold, core_start, busy, done;
  logic [31:0] core_pc, checksum;
  logic [1:0]  error;
  logic        core_halted = 1'b1;

  mips32_prog_loader_if #(.ADDR_W(10)) bus ();

  mips32_prog_loader #(.ADDR_W(10), .DEPTH(1024), .TIMEOUT_CYC(16)) dut (
    .clk1(clk1), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .bus(bus), .core_hold(core_hold),
    .core_start(core_start), .core_pc(core_pc), .core_halted(core_halted),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_tests = 0, n_fail = 0, n_writes = 0, n_starts = 0;
  logic [31:0] exp_pc = '0;
  bit rand_gaps = 0;

  logic [31:0] mem  [0:1023] = '{default: 32'd0};
  logic [31:0] regs [0:31]   = '{default: 32'd0};
  logic [9:0]  pc = '0;
  logic        running = 1'b0;
  logic [31:0] ir;

  logic [31:0] prog1 [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                               32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                               32'hfc000000};

  always @(posedge clk1) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  // core model: one instruction per cycle while released
  always @(posedge clk1) begin
    if (core_start) begin
      pc <= core_pc[9:0];
      core_halted <= 1'b0;
      running <= 1'b1;
    end else if (running && !core_hold) begin
      ir = mem[pc];
      case (ir[31:26])
        6'h0a: if (ir[20:16] != 5'd0)
                 regs[ir[20:16]] <= regs[ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
        6'h00: if (ir[15:11] != 5'd0)
                 regs[ir[15:11]] <= regs[ir[25:21]] + regs[ir[20:16]];
        6'h3f: begin core_halted <= 1'b1; running <= 1'b0; end
        default: ;
      endcase
      pc <= pc + 10'd1;
    end
  end

  always @(negedge clk1) begin
    if (bus.mem_we) begin
      n_writes++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.mem_addr !== mon_e.a || bus.mem_wdata !== mon_e.d) begin
          n_fail++;
          $display("FAIL mem_write actual=%0d:%h required=%0d:%h",
                   bus.mem_addr, bus.mem_wdata, mon_e.a, mon_e.d);
        end
      end
    end
    if (core_start) begin
      n_starts++;
      n_tests++;
      if (core_pc !== exp_pc) begin
        n_fail++;
        $display("FAIL core_pc actual=%h required=%h", core_pc, exp_pc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_load(input logic [9:0] b, input logic [10:0] c);
    load_start = 1'b1; load_base = b; load_count = c;
    exp_pc = {22'd0, b};
    @(negedge clk1);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    int g = 0;
    if (rand_gaps)
      while ($urandom_range(0, 2) != 0) begin bus.s_valid = 1'b0; @(negedge clk1); end
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    while (!bus.s_ready && g < 50) begin @(negedge clk1); g++; end
    if (g >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL s_ready_wait timed out");
    end
    @(negedge clk1);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic wait_end(input int maxc);
    int c = 0;
    while (!done && error == 2'b00 && c < maxc) begin @(negedge clk1); c++; end
    n_tests++;
    if (c >= maxc) begin
      n_fail++;
      $display("FAIL wait_end timed out after %0d cycles", c);
    end
  endtask

  initial begin
    int s0, w0, c, rdy;
    logic [31:0] w3 [0:3];
    logic [31:0] w6 [0:2];
    w3 = '{32'h2801000a, 32'h28020014, 32'h00222000, 32'hfc000000};
    w6 = '{32'h28010005, 32'h28020007, 32'hfc000000};
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_count = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (3) @(negedge clk1);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_core_pc", core_pc, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_error", {30'd0, error}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    rst = 1'b0;
    @(negedge clk1);

    // 1: nine-word program at base 0
    s0 = n_starts; w0 = n_writes;
    start_load(10'd0, 11'd9);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 9; i++) send_word(10'(i), prog1[i]);
    wait_end(100);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_error", {30'd0, error}, 32'd0);
    chk("t1_checksum", checksum, 32'h9b61b037);
    chk("t1_starts", n_starts - s0, 32'd1);
    chk("t1_writes", n_writes - w0, 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("t1_mem%0d", i), mem[i], prog1[i]);
    chk("t1_r3", regs[3], 32'd25);
    chk("t1_r4", regs[4], 32'd30);
    chk("t1_r5", regs[5], 32'd55);
    chk("t1_core_hold", {31'd0, core_hold}, 32'd0);

    // 2: two words, checksum wraps
    w0 = n_writes;
    start_load(10'd100, 11'd2);
    send_word(10'd100, 32'h2801000a);
    send_word(10'd101, 32'hfc000000);
    wait_end(100);
    chk("t2_checksum", checksum, 32'h2401000a);
    chk("t2_writes", n_writes - w0, 32'd2);
    chk("t2_done", {31'd0, done}, 32'd1);

    // 3: range errors, then the exact-fit boundary
    w0 = n_writes; s0 = n_starts;
    start_load(10'd1020, 11'd5);
    bus.s_valid = 1'b1; bus.s_data = 8'h55; rdy = 0;
    for (int i = 0; i < 6; i++) begin rdy += int'(bus.s_ready); @(negedge clk1); end
    bus.s_valid = 1'b0;
    chk("t3_error_range", {30'd0, error}, 32'd1);
    chk("t3_ready_range", rdy, 32'd0);
    chk("t3_busy_range", {30'd0, busy, done}, 32'd0);
    start_load(10'd0, 11'd0);
    bus.s_valid = 1'b1; rdy = 0;
    for (int i = 0; i < 6; i++) begin rdy += int'(bus.s_ready); @(negedge clk1); end
    bus.s_valid = 1'b0;
    chk("t3_error_zero", {30'd0, error}, 32'd1);
    chk("t3_ready_zero", rdy, 32'd0);
    chk("t3_nowrites", n_writes - w0, 32'd0);
    chk("t3_nostarts", n_starts - s0, 32'd0);
    start_load(10'd1020, 11'd4);
    chk("t3_err_cleared", {30'd0, error}, 32'd0);
    for (int i = 0; i < 4; i++) send_word(10'(1020 + i), w3[i]);
    wait_end(100);
    chk("t3_edge_done", {31'd0, done}, 32'd1);
    chk("t3_edge_checksum", checksum, 32'h4c25201e);

    // 4: same program with a sparse s_valid
    rand_gaps = 1;
    start_load(10'd500, 11'd9);
    for (int i = 0; i < 9; i++) send_word(10'(500 + i), prog1[i]);
    rand_gaps = 0;
    wait_end(100);
    chk("t4_checksum", checksum, 32'h9b61b037);
    for (int i = 0; i < 9; i++) chk($sformatf("t4_mem%0d", i), mem[500 + i], prog1[i]);

    // 5: watchdog with no HLT
    start_load(10'd300, 11'd2);
    send_word(10'd300, 32'h2801000a);
    send_word(10'd301, 32'h28020014);
    c = 0;
    while (!core_start && c < 20) begin @(negedge clk1); c++; end
    chk("t5_release_seen", {31'd0, core_start}, 32'd1);
    c = 0;
    while (error != 2'b10 && c < 60) begin @(negedge clk1); c++; end
    chk("t5_timeout_cycles", c, 32'd16);
    chk("t5_error", {30'd0, error}, 32'd2);
    chk("t5_core_hold", {31'd0, core_hold}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);

    // 6: ignored load_start during LOAD, then reset after 6 bytes
    w0 = n_writes;
    start_load(10'd200, 11'd3);
    send_word(10'd200, w6[0]);
    load_start = 1'b1; load_base = 10'd0; load_count = 11'd1;
    send_byte(w6[1][31:24]);
    load_start = 1'b0;
    send_byte(w6[1][23:16]);
    repeat (3) @(negedge clk1);
    chk("t6_still_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_core_hold", {31'd0, core_hold}, 32'd1);
    chk("t6_rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    @(negedge clk1);
    rst = 1'b0;
    chk("t6_idle", {30'd0, busy, done}, 32'd0);
    chk("t6_core_hold", {31'd0, core_hold}, 32'd1);
    chk("t6_partial_writes", n_writes - w0, 32'd1);
    chk("t6_queue_empty", exp_q.size(), 32'd0);
    start_load(10'd200, 11'd3);
    for (int i = 0; i < 3; i++) send_word(10'(200 + i), w6[i]);
    wait_end(100);
    chk("t6_reload_done", {31'd0, done}, 32'd1);
    chk("t6_reload_checksum", checksum, 32'h4c03000c);
    chk("t6_mem201", mem[201], w6[1]);

    repeat (3) @(negedge clk1);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached");
    $fatal(1, "bench did not terminate");
  end

endmodule
